// File: rtl/data_mem_ctrl.sv
// Single-port word memory with a zero-fill sweep after reset or clear, then one request per cycle.
// Read latency is 1 cycle. req_ready is low during the sweep and in any cycle where clear is high.
module data_mem_ctrl #(
  parameter int N     = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          rd_valid,
  output logic [N-1:0]  rd_data,
  output logic          err,
  output logic          init_done
);

  typedef enum logic {INIT, READY} state_t;

  // The counter is one bit wider than the address so DEPTH == 2**AW still fits.
  localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW:0]   cnt;
  logic [N-1:0]  mem [DEPTH];

  logic          accept;
  logic          in_range;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;

  assign req_ready = (state == READY) && !clear;
  assign init_done = (state == READY);

  always_comb begin
    in_range  = ({1'b0, req_addr} < DEPTH_W);
    accept    = req_valid && req_ready;
    mem_we    = 1'b0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = cnt[AW-1:0];
      mem_wdata = '0;
    end else begin
      mem_we    = accept && req_we && in_range;
    end
  end

  // Memory has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        INIT: begin
          if (cnt == LAST) begin
            state <= READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          if (clear) begin
            state <= INIT;
            cnt   <= '0;
          end else if (accept) begin
            err <= !in_range;
            if (!req_we) begin
              rd_valid <= 1'b1;
              rd_data  <= in_range ? mem[req_addr] : '0;
            end
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a DEPTH=512 instance plus a DEPTH=300 instance sharing stimulus.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        req_valid;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;

  logic        req_ready, rd_valid, err, init_done;
  logic [15:0] rd_data;
  logic        req_ready_b, rd_valid_b, err_b, init_done_b;
  logic [15:0] rd_data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc, n_cyc_b;

  always #5 clk = ~clk;

  data_mem_ctrl #(.N(16), .AW(9), .DEPTH(512)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .init_done(init_done)
  );

  data_mem_ctrl #(.N(16), .AW(9), .DEPTH(300)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .err(err_b), .init_done(init_done_b)
  );

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        exp_rv;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic we, input logic [8:0] a, input logic [15:0] d);
    @(negedge clk);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clear     = 1'b0;
  endtask

  // Counts rising edges until init_done; also records when the small instance finished.
  task automatic wait_ready(output int n, output int n_b);
    n   = 0;
    n_b = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (init_done_b && n_b == 0) n_b = i;
      if (init_done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start_clear();
    @(negedge clk);
    clear     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 9'd5;
    req_wdata = 16'h7777;
    #1;
    check("clear_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    check("clear_init_done", {31'b0, init_done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 9'd0,   16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 9'd255, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[2] = '{1'b0, 9'd511, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{1'b1, 9'd5,   16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[4] = '{1'b0, 9'd5,   16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vecs[5] = '{1'b1, 9'd6,   16'h1234, 1'b0, 1'b0, 16'hBEEF};
    vecs[6] = '{1'b0, 9'd6,   16'h0000, 1'b1, 1'b0, 16'h1234};
    vecs[7] = '{1'b1, 9'd511, 16'hFFFF, 1'b0, 1'b0, 16'h1234};
    vecs[8] = '{1'b0, 9'd511, 16'h0000, 1'b1, 1'b0, 16'hFFFF};

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_rd_valid",  {31'b0, rd_valid},  32'd0);
    check("rst_err",       {31'b0, err},       32'd0);
    check("rst_rd_data",   {16'b0, rd_data},   32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n_cyc, n_cyc_b);
    check("sweep_cycles_512", n_cyc, 32'd512);
    check("sweep_cycles_300", n_cyc_b, 32'd300);
    check("ready_after_sweep", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      step(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rd_valid", i), {31'b0, rd_valid}, {31'b0, vecs[i].exp_rv});
      check($sformatf("vec%0d_err", i),      {31'b0, err},      {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_rd_data", i),  {16'b0, rd_data},  {16'b0, vecs[i].exp_rd});
    end

    // Out-of-range behaviour on the DEPTH=300 instance.
    step(1'b1, 1'b1, 9'd299, 16'h5555);
    check("oor_w299_err", {31'b0, err_b}, 32'd0);
    step(1'b1, 1'b1, 9'd300, 16'hAAAA);
    check("oor_w300_err", {31'b0, err_b}, 32'd1);
    check("oor_w300_rv",  {31'b0, rd_valid_b}, 32'd0);
    step(1'b1, 1'b0, 9'd299, 16'h0000);
    check("oor_r299_data", {16'b0, rd_data_b}, 32'h5555);
    check("oor_r299_err",  {31'b0, err_b}, 32'd0);
    step(1'b1, 1'b0, 9'd300, 16'h0000);
    check("oor_r300_err",  {31'b0, err_b}, 32'd1);
    check("oor_r300_rv",   {31'b0, rd_valid_b}, 32'd1);
    check("oor_r300_data", {16'b0, rd_data_b}, 32'h0000);
    check("big_r300_data", {16'b0, rd_data}, 32'hAAAA);
    check("big_r300_err",  {31'b0, err}, 32'd0);
    step(1'b0, 1'b0, 9'd300, 16'h0000);
    check("oor_err_pulse_end", {31'b0, err_b}, 32'd0);
    check("oor_rv_pulse_end",  {31'b0, rd_valid_b}, 32'd0);

    // Back-to-back throughput.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 9'(i), 16'h0010 + 16'(i));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 9'(i), 16'h0000);
      check($sformatf("burst%0d_rv", i),   {31'b0, rd_valid}, 32'd1);
      check($sformatf("burst%0d_data", i), {16'b0, rd_data}, 32'h0010 + i);
    end
    step(1'b0, 1'b0, 9'd0, 16'h0000);
    check("burst_rv_end", {31'b0, rd_valid}, 32'd0);

    // Clear wins over a simultaneous request and re-zeroes memory.
    start_clear();
    wait_ready(n_cyc, n_cyc_b);
    check("clear_sweep_512", n_cyc, 32'd512);
    check("clear_sweep_300", n_cyc_b, 32'd300);
    check("clear_rd_data_held", {16'b0, rd_data}, 32'h0017);
    step(1'b1, 1'b0, 9'd5, 16'h0000);
    check("clear_r5_rv",   {31'b0, rd_valid}, 32'd1);
    check("clear_r5_data", {16'b0, rd_data}, 32'h0000);
    step(1'b1, 1'b0, 9'd7, 16'h0000);
    check("clear_r7_data", {16'b0, rd_data}, 32'h0000);

    step(1'b1, 1'b1, 9'd9, 16'hCAFE);
    step(1'b1, 1'b0, 9'd9, 16'h0000);
    check("r9_data", {16'b0, rd_data}, 32'hCAFE);

    // Reset in the middle of a sweep.
    start_clear();
    repeat (99) @(posedge clk);
    #3;
    check("mid_sweep_not_done", {31'b0, init_done}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_rd_data",   {16'b0, rd_data},   32'd0);
    check("midrst_req_ready", {31'b0, req_ready}, 32'd0);
    check("midrst_init_done", {31'b0, init_done}, 32'd0);
    check("midrst_rd_valid",  {31'b0, rd_valid},  32'd0);
    check("midrst_err",       {31'b0, err},       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n_cyc, n_cyc_b);
    check("midrst_sweep_512", n_cyc, 32'd512);
    check("midrst_sweep_300", n_cyc_b, 32'd300);
    step(1'b1, 1'b0, 9'd9, 16'h0000);
    check("midrst_r9_data", {16'b0, rd_data}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter AW, default 9, meaning address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 512, meaning the number of implemented words, with 1 <= DEPTH <= 2**AW.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous request to restart the zero-fill sweep.
REQ-007 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-008 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, AW bits: word address.
REQ-011 The block SHALL have port req_wdata, input, N bits: write data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking rd_data as new read data.
REQ-013 The block SHALL have port rd_data, output, N bits: registered read data.
REQ-014 The block SHALL have port err, output, 1 bit: one-cycle pulse for an accepted out-of-range request.
REQ-015 The block SHALL have port init_done, output, 1 bit: high when the memory is zero-filled and the block is in READY.

Function
REQ-016 The FSM SHALL have exactly two states: INIT (zero-fill sweep) and READY.
REQ-017 In INIT, a sweep counter SHALL run from 0 to DEPTH-1, writing 0 to mem[counter] on each cycle, one word per cycle.
REQ-018 The cycle that writes word DEPTH-1 SHALL move the FSM to READY, so INIT lasts exactly DEPTH cycles.
REQ-019 In READY, clear=1 SHALL move the FSM to INIT with counter=0 on the next edge.
REQ-020 In INIT, clear SHALL be ignored.
REQ-021 req_ready SHALL equal (state==READY) AND NOT clear.
REQ-022 init_done SHALL equal (state==READY).
REQ-023 A request SHALL be accepted only on an edge where req_valid=1 and req_ready=1; otherwise the request inputs SHALL be ignored.
REQ-024 An accepted write with req_addr < DEPTH SHALL set mem[req_addr] = req_wdata at that edge, with no rd_valid pulse.
REQ-025 An accepted read with req_addr < DEPTH SHALL load rd_data with mem[req_addr] and assert rd_valid for exactly one cycle after the accepting edge (read latency 1).
REQ-026 A write followed by a read of the same address on the next accepted cycle SHALL return the new data.
REQ-027 An accepted request with req_addr >= DEPTH SHALL pulse err for one cycle.
REQ-028 An out-of-range write SHALL modify no memory.
REQ-029 An out-of-range read SHALL load rd_data with 0 and also pulse rd_valid.
REQ-030 rd_data SHALL hold its value between reads; it SHALL NOT change on writes, on clear, or during INIT.
REQ-031 Back-to-back accepted requests SHALL be supported every cycle with no bubble.
REQ-032 rd_valid and err SHALL be 0 in every cycle not directly following an accepted request that raises them.
REQ-033 Widths: the counter SHALL be AW+1 bits or wider, so that DEPTH=2**AW terminates without wrap.
REQ-034 All address compares SHALL be unsigned.

Reset
REQ-035 rst_n=0 SHALL, asynchronously: force state=INIT, counter=0, rd_data=0, rd_valid=0, err=0, req_ready=0, init_done=0.
REQ-036 Memory contents SHALL NOT be reset directly; they SHALL be zeroed by the sweep that starts when rst_n deasserts.
REQ-037 Reset asserted mid-sweep or mid-request SHALL abandon the operation and restart the full sweep from 0.

Verification
REQ-038 Reset and sweep: release rst_n with DEPTH=512 -> req_ready=0 for exactly 512 cycles, then init_done=1; reads of addr 0, 255 and 511 return 0x0000.
REQ-039 Write/read: write 0xBEEF to addr 5, then read addr 5 on the next cycle -> rd_valid pulses 1 cycle later with rd_data=0xBEEF; rd_data stays 0xBEEF after a following write of 0x1234 to addr 6.
REQ-040 Out of range: with DEPTH=300, AW=9, write 0xAAAA to addr 300, then read addr 300 -> err pulses on both; the read returns rd_valid=1, rd_data=0x0000; addr 299 is unchanged.
REQ-041 Clear priority: clear=1 with req_valid=1 in READY -> request not accepted (req_ready=0), INIT re-entered; after DEPTH cycles, addr 5 reads 0x0000.
REQ-042 Reset mid-sweep: assert rst_n=0 at sweep count 100 -> outputs go to reset values immediately; after release, the sweep takes the full DEPTH cycles again.
REQ-043 Throughput: 8 consecutive accepted reads of addrs 0..7 pre-written with 0x0010..0x0017 -> 8 consecutive rd_valid cycles returning those values in order.
